uart_tx_scheduler: RTL and testbench
====================================

UART_TX_SCHEDULER -- requirements
Module: uart_tx_scheduler

Interface
REQ-001 The block SHALL have parameter ClockFrequency, default 1000000, meaning the clock frequency in Hz.
REQ-002 The block SHALL have parameter BaudRate, default 9600, meaning the line rate in bit/s.
REQ-003 The block SHALL have parameter NrOfDataBits, default 8, meaning the data bits per frame.
REQ-004 The block SHALL have parameter NrOfStopBits, default 1, meaning the stop bits per frame (1 or 2).
REQ-005 The block SHALL have port clock  input  1  single clock; all logic on its rising edge.
REQ-006 The block SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-007 The block SHALL have port request0  input  1  requester 0 wants to send a frame.
REQ-008 The block SHALL have port data0  input  NrOfDataBits  requester 0 payload.
REQ-009 The block SHALL have port grant0  output  1  one-cycle pulse: data0 accepted.
REQ-010 The block SHALL have port request1  input  1  requester 1 wants to send a frame.
REQ-011 The block SHALL have port data1  input  NrOfDataBits  requester 1 payload.
REQ-012 The block SHALL have port grant1  output  1  one-cycle pulse: data1 accepted.
REQ-013 The block SHALL have port busy  output  1  a frame is on the line.
REQ-014 The block SHALL have port tx  output  1  serial line, idle high.

Function
REQ-015 BitTicks SHALL be ClockFrequency/BaudRate using integer division, and elaboration SHALL fail if the result is below 1.
REQ-016 The states SHALL be IDLE, START, DATA and STOP.
REQ-017 Arbitration SHALL take place on an edge where the state is IDLE, or on the final cycle of STOP, and at least one request is sampled high.
REQ-018 On that edge the block SHALL latch the winner's data, pulse that grant for exactly one cycle, set busy=1, set tx=0 and enter START.
REQ-019 With a single requester, that requester SHALL win.
REQ-020 With both requesters, the one not served last SHALL win (round-robin).
REQ-021 grant0 and grant1 SHALL never be high in the same cycle.
REQ-022 START SHALL hold tx=0 for BitTicks cycles.
REQ-023 DATA SHALL drive the latched bits LSB first, each bit for BitTicks cycles.
REQ-024 STOP SHALL hold tx=1 for NrOfStopBits*BitTicks cycles.
REQ-025 Frame length SHALL be (1+NrOfDataBits+NrOfStopBits)*BitTicks cycles, measured from the grant edge.
REQ-026 A request pending at the final STOP cycle SHALL start the next frame on the following edge with zero idle cycles; otherwise the state SHALL return to IDLE with tx=1 and busy=0.
REQ-027 A requester SHALL hold request and data until its grant; a request dropped before grant SHALL produce no frame, and data changes after grant SHALL not affect the frame.
REQ-028 A request that stays high after its grant SHALL be treated as a new frame request.
REQ-029 The baud counter SHALL restart at every frame start, with no drift carried between frames.

Reset
REQ-030 Reset SHALL immediately force state IDLE, tx=1, busy=0, grant0=0, grant1=0, counters=0 and last-served=requester 1, so requester 0 wins the first tie.
REQ-031 Reset during a frame SHALL abort it with no resumption; after release, pending requests SHALL start fresh frames.

Structure
REQ-032 The shared package uart_pkg SHALL hold the state encoding and the BitTicks computation/check.
REQ-033 Bit timing SHALL be one sub-module, uart_baud_counter (clear input, one-cycle bitTick output every BitTicks cycles); all else inline.

Verification (ClockFrequency=16, BaudRate=4 -> BitTicks=4, NrOfDataBits=8, NrOfStopBits=1, frame 40 cycles)
REQ-034 A single request0 with data0=0xA5 SHALL give one grant0 pulse, tx segments 0,1,0,1,0,0,1,0,1,1 of 4 cycles each, and busy high for 40 cycles.
REQ-035 When request0 and request1 rise together after reset, grant0 SHALL occur first and grant1 exactly 40 cycles later, with tx showing no idle-high gap between frames.
REQ-036 When both requests are held high for 4 frames, grants SHALL alternate 0,1,0,1 at 40-cycle spacing.
REQ-037 Reset asserted 10 cycles into a frame SHALL force tx=1 and busy=0 immediately; with request1 held, a full new 40-cycle frame SHALL follow release.
REQ-038 A request1 raised then dropped while busy, before the final STOP cycle, SHALL produce no grant1 and no second frame.
REQ-039 With NrOfStopBits=2, STOP SHALL last 8 cycles and the frame 44 cycles.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the two-requester UART transmit scheduler:
// FSM state encoding and bit-period arithmetic.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  function automatic int bit_ticks(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

  function automatic bit bit_ticks_ok(input int ticks);
    return ticks >= 1;
  endfunction

  // Counter width that stays legal when the count range collapses to one value.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_scheduler_if.sv
// Requester/line bundle between the two requesters and the scheduler.
interface uart_tx_scheduler_if #(
  parameter int NrOfDataBits = 8
);
  logic                    request0;
  logic [NrOfDataBits-1:0] data0;
  logic                    grant0;
  logic                    request1;
  logic [NrOfDataBits-1:0] data1;
  logic                    grant1;
  logic                    busy;
  logic                    tx;

  modport master (
    output request0, data0, request1, data1,
    input  grant0, grant1, busy, tx
  );

  modport slave (
    input  request0, data0, request1, data1,
    output grant0, grant1, busy, tx
  );
endinterface

// File: rtl/uart_baud_counter.sv
// Bit-period timer: bitTick pulses on the last cycle of every BitTicks-cycle period.
module uart_baud_counter
  import uart_pkg::*;
#(
  parameter int BitTicks = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  output logic bitTick
);

  localparam int              W    = cnt_width(BitTicks);
  localparam logic [W-1:0]    LAST = W'(BitTicks - 1);

  logic [W-1:0] cnt_q, cnt_d;

  // Tick is decoded from the count alone so clear may depend on it without a loop.
  assign bitTick = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clear || bitTick) cnt_d = '0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler feeding two requesters onto one UART transmit line;
// frames may run back to back with no idle bit between them.
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int ClockFrequency = 1000000,
  parameter int BaudRate       = 9600,
  parameter int NrOfDataBits   = 8,
  parameter int NrOfStopBits   = 1
) (
  input  logic                clock,
  input  logic                reset,
  uart_tx_scheduler_if.slave  bus
);

  localparam int BitTicks = bit_ticks(ClockFrequency, BaudRate);
  localparam int BW       = cnt_width(NrOfDataBits);
  localparam logic [BW-1:0] LAST_BIT  = BW'(NrOfDataBits - 1);
  localparam logic          LAST_STOP = (NrOfStopBits == 2);

  generate
    if (!bit_ticks_ok(BitTicks)) begin : g_bad_baud
      $error("uart_tx_scheduler: ClockFrequency/BaudRate must be at least 1");
    end
    if (NrOfStopBits < 1 || NrOfStopBits > 2) begin : g_bad_stop
      $error("uart_tx_scheduler: NrOfStopBits must be 1 or 2");
    end
  endgenerate

  uart_state_e             state_q, state_d;
  logic [NrOfDataBits-1:0] shift_q, shift_d;
  logic [BW-1:0]           bit_q, bit_d;
  logic                    stop_q, stop_d;
  logic                    last_q, last_d;
  logic                    grant0_q, grant0_d;
  logic                    grant1_q, grant1_d;
  logic                    busy_q, busy_d;
  logic                    tx_q, tx_d;

  logic tick, clr, final_stop, arb, start, win;

  uart_baud_counter #(.BitTicks(BitTicks)) u_baud (
    .clock   (clock),
    .reset   (reset),
    .clear   (clr),
    .bitTick (tick)
  );

  assign final_stop = (state_q == STOP) && tick && (stop_q == LAST_STOP);
  assign arb        = (state_q == IDLE) || final_stop;
  assign start      = arb && (bus.request0 || bus.request1);
  // win=1 selects requester 1; on a tie the one not served last goes.
  assign win        = (bus.request0 && bus.request1) ? ~last_q : bus.request1;
  assign clr        = start || (state_q == IDLE);

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    bit_d    = bit_q;
    stop_d   = stop_q;
    last_d   = last_q;
    grant0_d = 1'b0;
    grant1_d = 1'b0;
    busy_d   = busy_q;
    tx_d     = tx_q;
    if (start) begin
      state_d  = START;
      shift_d  = win ? bus.data1 : bus.data0;
      last_d   = win;
      grant0_d = ~win;
      grant1_d = win;
      busy_d   = 1'b1;
      tx_d     = 1'b0;
      bit_d    = '0;
      stop_d   = 1'b0;
    end else begin
      case (state_q)
        START: if (tick) begin
          state_d = DATA;
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
          bit_d   = '0;
        end
        DATA: if (tick) begin
          if (bit_q == LAST_BIT) begin
            state_d = STOP;
            tx_d    = 1'b1;
            stop_d  = 1'b0;
          end else begin
            bit_d   = bit_q + 1'b1;
            tx_d    = shift_q[0];
            shift_d = shift_q >> 1;
          end
        end
        STOP: if (tick) begin
          if (final_stop) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            tx_d    = 1'b1;
          end else begin
            stop_d  = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      bit_q    <= '0;
      stop_q   <= 1'b0;
      last_q   <= 1'b1;
      grant0_q <= 1'b0;
      grant1_q <= 1'b0;
      busy_q   <= 1'b0;
      tx_q     <= 1'b1;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      bit_q    <= bit_d;
      stop_q   <= stop_d;
      last_q   <= last_d;
      grant0_q <= grant0_d;
      grant1_q <= grant1_d;
      busy_q   <= busy_d;
      tx_q     <= tx_d;
    end
  end

  assign bus.grant0 = grant0_q;
  assign bus.grant1 = grant1_q;
  assign bus.busy   = busy_q;
  assign bus.tx     = tx_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: one- and two-stop-bit instances against a
// frame-time reference model, with directed scenarios and random requesters.
module tb_uart_tx_scheduler;

  localparam int CF = 16, BR = 4, NB = 8, BT = CF / BR;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  uart_tx_scheduler_if #(.NrOfDataBits(NB)) ifa ();
  uart_tx_scheduler_if #(.NrOfDataBits(NB)) ifb ();

  uart_tx_scheduler #(.ClockFrequency(CF), .BaudRate(BR), .NrOfDataBits(NB), .NrOfStopBits(1))
    dut_a (.clock(clock), .reset(reset), .bus(ifa.slave));
  uart_tx_scheduler #(.ClockFrequency(CF), .BaudRate(BR), .NrOfDataBits(NB), .NrOfStopBits(2))
    dut_b (.clock(clock), .reset(reset), .bus(ifb.slave));

  logic          r0 [2], r1 [2];
  logic [NB-1:0] d0 [2], d1 [2];
  logic          g0 [2], g1 [2], bz [2], txo [2];

  assign ifa.request0 = r0[0];
  assign ifa.data0    = d0[0];
  assign ifa.request1 = r1[0];
  assign ifa.data1    = d1[0];
  assign ifb.request0 = r0[1];
  assign ifb.data0    = d0[1];
  assign ifb.request1 = r1[1];
  assign ifb.data1    = d1[1];
  assign g0[0] = ifa.grant0;
  assign g1[0] = ifa.grant1;
  assign bz[0] = ifa.busy;
  assign txo[0] = ifa.tx;
  assign g0[1] = ifb.grant0;
  assign g1[1] = ifb.grant1;
  assign bz[1] = ifb.busy;
  assign txo[1] = ifb.tx;

  // Reference: a frame is "t cycles since grant"; line value follows from t alone.
  int            flen [2];
  int            t_m [2];
  bit            busy_m [2], last_m [2], g0_m [2], g1_m [2];
  logic [NB-1:0] dat_m [2];

  int n_chk = 0, n_err = 0;
  bit rnd = 1'b0, keep = 1'b0;
  bit tx_log [2][0:255];
  int nlog;
  int fg0 [2], fg1 [2], g0cnt [2], g1cnt [2], busycnt [2], ng [2];
  int gseq [2][0:7], gcyc [2][0:7];
  int seg [10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic bit exp_tx(input int k);
    int b;
    if (!busy_m[k]) return 1'b1;
    if (t_m[k] < BT) return 1'b0;
    b = t_m[k] / BT - 1;
    if (b < NB) return dat_m[k][b];
    return 1'b1;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      busy_m[k] = 1'b0;
      t_m[k]    = 0;
      last_m[k] = 1'b1;
      g0_m[k]   = 1'b0;
      g1_m[k]   = 1'b0;
    end
  endtask

  task automatic model_step(input int k);
    bit arb, w;
    arb = !busy_m[k] || (t_m[k] == flen[k] - 1);
    g0_m[k] = 1'b0;
    g1_m[k] = 1'b0;
    if (arb && (r0[k] || r1[k])) begin
      w = (r0[k] && r1[k]) ? !last_m[k] : r1[k];
      last_m[k] = w;
      dat_m[k]  = w ? d1[k] : d0[k];
      g0_m[k]   = !w;
      g1_m[k]   = w;
      busy_m[k] = 1'b1;
      t_m[k]    = 0;
    end else if (arb) begin
      busy_m[k] = 1'b0;
      t_m[k]    = 0;
    end else begin
      t_m[k]++;
    end
  endtask

  task automatic clear_log();
    nlog = 0;
    for (int k = 0; k < 2; k++) begin
      fg0[k] = -1; fg1[k] = -1;
      g0cnt[k] = 0; g1cnt[k] = 0; busycnt[k] = 0; ng[k] = 0;
    end
  endtask

  task automatic observe(input int k);
    string p;
    p = (k == 0) ? "a." : "b.";
    chk({p, "tx"},     int'(txo[k]), int'(exp_tx(k)));
    chk({p, "busy"},   int'(bz[k]),  int'(busy_m[k]));
    chk({p, "grant0"}, int'(g0[k]),  int'(g0_m[k]));
    chk({p, "grant1"}, int'(g1[k]),  int'(g1_m[k]));
    chk({p, "excl"},   int'(g0[k] & g1[k]), 0);
    if (nlog < 256) tx_log[k][nlog] = txo[k];
    if (bz[k]) busycnt[k]++;
    if (g0[k]) begin g0cnt[k]++; if (fg0[k] < 0) fg0[k] = nlog; end
    if (g1[k]) begin g1cnt[k]++; if (fg1[k] < 0) fg1[k] = nlog; end
    if ((g0[k] || g1[k]) && ng[k] < 8) begin
      gseq[k][ng[k]] = int'(g1[k]);
      gcyc[k][ng[k]] = nlog;
      ng[k]++;
    end
  endtask

  task automatic cycle();
    @(posedge clock);
    if (reset) model_reset();
    else for (int k = 0; k < 2; k++) model_step(k);
    @(negedge clock);
    for (int k = 0; k < 2; k++) observe(k);
    nlog++;
  endtask

  // Requesters hold request/data until granted; in random mode a granted
  // requester either drops or immediately asks again with new data.
  task automatic drive(input int k);
    if (rnd) begin
      if (g0[k]) begin
        if ($urandom_range(1) == 0) r0[k] = 1'b0; else d0[k] = NB'($urandom);
      end else if (!r0[k] && $urandom_range(5) == 0) begin
        r0[k] = 1'b1; d0[k] = NB'($urandom);
      end
      if (g1[k]) begin
        if ($urandom_range(1) == 0) r1[k] = 1'b0; else d1[k] = NB'($urandom);
      end else if (!r1[k] && $urandom_range(5) == 0) begin
        r1[k] = 1'b1; d1[k] = NB'($urandom);
      end
    end else begin
      if (g0[k] && !keep) r0[k] = 1'b0;
      if (g1[k] && !keep) r1[k] = 1'b0;
    end
  endtask

  task automatic step();
    cycle();
    drive(0);
    drive(1);
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      r0[k] = 1'b0; r1[k] = 1'b0; d0[k] = '0; d1[k] = '0;
      flen[k] = (1 + NB + 1 + k) * BT;
    end
    model_reset();
    clear_log();
    repeat (3) cycle();
    reset = 1'b0;

    // Single request0 carrying 0xA5.
    clear_log();
    for (int k = 0; k < 2; k++) begin r0[k] = 1'b1; d0[k] = 8'hA5; end
    repeat (60) step();
    chk("t1.grant0_a", g0cnt[0], 1);
    chk("t1.grant0_b", g0cnt[1], 1);
    chk("t1.busy_a", busycnt[0], 40);
    chk("t1.busy_b", busycnt[1], 44);
    chk("t1.started", int'(fg0[0] >= 0 && fg0[1] >= 0), 1);
    if (fg0[0] >= 0)
      for (int s = 0; s < 10; s++)
        for (int j = 0; j < BT; j++)
          chk($sformatf("t1.seg%0d", s), int'(tx_log[0][fg0[0] + BT*s + j]), seg[s]);
    if (fg0[1] >= 0) begin
      for (int j = 0; j < 2*BT; j++) chk("t1.stop2", int'(tx_log[1][fg0[1] + 36 + j]), 1);
      chk("t1.idle2", int'(tx_log[1][fg0[1] + 44]), 1);
    end

    // Simultaneous requests straight after reset.
    reset = 1'b1; model_reset(); cycle(); reset = 1'b0;
    clear_log();
    for (int k = 0; k < 2; k++) begin
      r0[k] = 1'b1; r1[k] = 1'b1; d0[k] = NB'($urandom); d1[k] = NB'($urandom);
    end
    repeat (100) step();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("t2.order%0d", k), int'(fg0[k] >= 0 && fg1[k] > fg0[k]), 1);
      chk($sformatf("t2.gap%0d", k), fg1[k] - fg0[k], flen[k]);
      chk($sformatf("t2.busy%0d", k), busycnt[k], 2 * flen[k]);
      chk($sformatf("t2.g1cnt%0d", k), g1cnt[k], 1);
      if (fg1[k] >= 0) chk($sformatf("t2.nogap%0d", k), int'(tx_log[k][fg1[k]]), 0);
    end

    // Both requests held for several frames.
    clear_log(); keep = 1'b1;
    for (int k = 0; k < 2; k++) begin r0[k] = 1'b1; r1[k] = 1'b1; end
    repeat (170) step();
    keep = 1'b0;
    for (int k = 0; k < 2; k++) begin r0[k] = 1'b0; r1[k] = 1'b0; end
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("t3.ngrants%0d", k), int'(ng[k] >= 4), 1);
      for (int i = 0; i < 4; i++) chk($sformatf("t3.seq%0d_%0d", k, i), gseq[k][i], i % 2);
      for (int i = 1; i < 4; i++) chk($sformatf("t3.space%0d_%0d", k, i), gcyc[k][i] - gcyc[k][i-1], flen[k]);
    end
    repeat (50) step();

    // Reset ten cycles into a frame, request1 held across it.
    clear_log(); keep = 1'b1;
    for (int k = 0; k < 2; k++) begin r1[k] = 1'b1; d1[k] = NB'($urandom); end
    for (int i = 0; i < 20 && fg1[0] < 0; i++) step();
    chk("t4.grant", int'(fg1[0] >= 0), 1);
    repeat (10) step();
    reset = 1'b1;
    model_reset();
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("t4.tx%0d", k), int'(txo[k]), 1);
      chk($sformatf("t4.busy%0d", k), int'(bz[k]), 0);
    end
    cycle(); cycle();
    keep = 1'b0; clear_log(); reset = 1'b0;
    repeat (60) step();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("t4.g1cnt%0d", k), g1cnt[k], 1);
      chk($sformatf("t4.busy_len%0d", k), busycnt[k], flen[k]);
    end

    // request1 raised and withdrawn mid-frame.
    clear_log();
    for (int k = 0; k < 2; k++) begin r0[k] = 1'b1; d0[k] = NB'($urandom); end
    repeat (5) step();
    for (int k = 0; k < 2; k++) begin r1[k] = 1'b1; d1[k] = NB'($urandom); end
    repeat (15) step();
    for (int k = 0; k < 2; k++) r1[k] = 1'b0;
    repeat (50) step();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("t5.g1cnt%0d", k), g1cnt[k], 0);
      chk($sformatf("t5.g0cnt%0d", k), g0cnt[k], 1);
      chk($sformatf("t5.busy%0d", k), busycnt[k], flen[k]);
    end

    // Random requesters against the model.
    clear_log(); rnd = 1'b1;
    repeat (3000) step();
    rnd = 1'b0;
    for (int k = 0; k < 2; k++) begin r0[k] = 1'b0; r1[k] = 1'b0; end
    repeat (60) step();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
